sram_req_arbiter: RTL and testbench

- Shares one req/addr_ok/data_ok SRAM-like bus between the fetch stage (instruction reads) and the execute stage (data load/store).
- Arbitrates each address phase between the two requesters.
- Holds a granted request stable until the bus accepts it.
- Tracks up to DEPTH outstanding transactions in an in-order ID FIFO, so each data_ok/rdata returns to the requester that issued it.
- Sits between the pipeline stages and the bus bridge; the execute stage's data_sram_* signals map onto the data-side port.

---
 rtl/sram_req_arbiter.sv | 125 ++++++++++++
 tb/tb_sram_req_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_req_arbiter.sv
// Shares one SRAM-like req/addr_ok/data_ok bus between the fetch and execute stages.
// Round-robin address arbitration, stall lock, and an in-order ID FIFO for responses.
module sram_req_arbiter #(
  parameter int DEPTH = 2,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            inst_req,
  input  logic [AW-1:0]   inst_addr,
  output logic            inst_addr_ok,
  output logic            inst_data_ok,
  output logic [DW-1:0]   inst_rdata,
  input  logic            data_req,
  input  logic            data_wr,
  input  logic [DW/8-1:0] data_wstrb,
  input  logic [AW-1:0]   data_addr,
  input  logic [DW-1:0]   data_wdata,
  output logic            data_addr_ok,
  output logic            data_data_ok,
  output logic [DW-1:0]   data_rdata,
  output logic            mem_req,
  output logic            mem_wr,
  output logic [DW/8-1:0] mem_wstrb,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic            mem_addr_ok,
  input  logic            mem_data_ok,
  input  logic [DW-1:0]   mem_rdata,
  output logic            proto_err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic {SRC_INST = 1'b0, SRC_DATA = 1'b1} src_e;

  logic          lock_q;
  src_e          owner_q;
  src_e          last_q;
  src_e          winner;
  src_e          fifo_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          issue_ok;
  logic          accept;
  logic          stall;
  logic          pop;
  src_e          head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A locked request keeps the bus until accepted; otherwise round-robin on ties.
  always_comb begin
    winner = SRC_INST;
    if (lock_q)
      winner = owner_q;
    else if (inst_req && data_req)
      winner = (last_q == SRC_INST) ? SRC_DATA : SRC_INST;
    else if (data_req)
      winner = SRC_DATA;
  end

  // A pop in this cycle deliberately does not free a slot until the next one.
  assign issue_ok = (count_q < CW'(DEPTH));
  assign mem_req  = issue_ok & (lock_q | inst_req | data_req);
  assign accept   = mem_req & mem_addr_ok;
  assign stall    = mem_req & ~mem_addr_ok;

  assign mem_addr  = (winner == SRC_DATA) ? data_addr : inst_addr;
  assign mem_wr    = (winner == SRC_DATA) & data_wr;
  assign mem_wstrb = mem_wr ? data_wstrb : '0;
  assign mem_wdata = (winner == SRC_DATA) ? data_wdata : '0;

  assign inst_addr_ok = accept & (winner == SRC_INST);
  assign data_addr_ok = accept & (winner == SRC_DATA);

  assign head         = fifo_q[rd_ptr_q];
  assign pop          = mem_data_ok & (count_q != '0);
  assign inst_data_ok = pop & (head == SRC_INST);
  assign data_data_ok = pop & (head == SRC_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_q    <= 1'b0;
      owner_q   <= SRC_INST;
      last_q    <= SRC_INST;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      proto_err <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
        last_q   <= winner;
        lock_q   <= 1'b0;
      end else if (stall) begin
        lock_q  <= 1'b1;
        owner_q <= winner;
      end
      if (pop)
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (accept && !pop)
        count_q <= count_q + CW'(1);
      else if (pop && !accept)
        count_q <= count_q - CW'(1);
      if (mem_data_ok && count_q == '0)
        proto_err <= 1'b1;
    end
  end

  // NOTE: the ID storage is not reset; count_q alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (accept)
      fifo_q[wr_ptr_q] <= winner;
  end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed self-checking bench for sram_req_arbiter (DEPTH=2): arbitration,
// stall lock, full stall, ordered return, protocol error and async reset.
module tb_sram_req_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            resetn;
  logic            inst_req;
  logic [AW-1:0]   inst_addr;
  logic            inst_addr_ok;
  logic            inst_data_ok;
  logic [DW-1:0]   inst_rdata;
  logic            data_req;
  logic            data_wr;
  logic [DW/8-1:0] data_wstrb;
  logic [AW-1:0]   data_addr;
  logic [DW-1:0]   data_wdata;
  logic            data_addr_ok;
  logic            data_data_ok;
  logic [DW-1:0]   data_rdata;
  logic            mem_req;
  logic            mem_wr;
  logic [DW/8-1:0] mem_wstrb;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic            mem_addr_ok;
  logic            mem_data_ok;
  logic [DW-1:0]   mem_rdata;
  logic            proto_err;

  int n_checks = 0;
  int n_fail   = 0;

  sram_req_arbiter #(.DEPTH(2), .AW(AW), .DW(DW)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here, outputs are sampled 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    inst_req = 0; inst_addr = '0;
    data_req = 0; data_wr = 0; data_wstrb = '0; data_addr = '0; data_wdata = '0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = '0;
  endtask

  initial begin
    clear_inputs();
    resetn    = 1'b0;
    mem_rdata = 32'h5555_aaaa;
    #2;
    check("rst_mem_req", mem_req, 0);
    check("rst_addr_ok", {inst_addr_ok, data_addr_ok}, 0);
    check("rst_data_ok", {inst_data_ok, data_data_ok}, 0);
    check("rst_proto_err", proto_err, 0);
    check("rst_inst_rdata_pass", inst_rdata, 32'h5555_aaaa);
    check("rst_data_rdata_pass", data_rdata, 32'h5555_aaaa);
    step();
    resetn = 1'b1;
    mem_rdata = '0;

    // Single fetch
    step();
    inst_req = 1; inst_addr = 32'h1c00_0000; mem_addr_ok = 1;
    #1;
    check("fetch_mem_req", mem_req, 1);
    check("fetch_mem_addr", mem_addr, 32'h1c00_0000);
    check("fetch_inst_addr_ok", inst_addr_ok, 1);
    check("fetch_data_addr_ok", data_addr_ok, 0);
    check("fetch_mem_wr_strb", {mem_wr, mem_wstrb}, 0);
    step();
    inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h0280_0c0c;
    #1;
    check("fetch_inst_data_ok", inst_data_ok, 1);
    check("fetch_data_data_ok", data_data_ok, 0);
    check("fetch_inst_rdata", inst_rdata, 32'h0280_0c0c);
    step();
    mem_data_ok = 0;

    // Tie round-robin: last winner is INST, so DATA, INST, DATA, INST
    inst_req = 1; inst_addr = 32'h1c00_0004;
    data_req = 1; data_addr = 32'h0000_0200; mem_addr_ok = 1;
    for (int i = 0; i < 4; i++) begin
      mem_data_ok = (i >= 1);
      #1;
      check($sformatf("rr%0d_data_addr_ok", i), data_addr_ok, (i % 2 == 0));
      check($sformatf("rr%0d_inst_addr_ok", i), inst_addr_ok, (i % 2 == 1));
      check($sformatf("rr%0d_mem_addr", i), mem_addr,
            (i % 2 == 0) ? 32'h0000_0200 : 32'h1c00_0004);
      check($sformatf("rr%0d_data_data_ok", i), data_data_ok, (i >= 1) && (i % 2 == 1));
      check($sformatf("rr%0d_inst_data_ok", i), inst_data_ok, (i >= 2) && (i % 2 == 0));
      step();
    end
    inst_req = 0; data_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
    #1;
    check("rr_drain_inst_data_ok", {inst_data_ok, data_data_ok}, 2'b10);
    step();
    mem_data_ok = 0;

    // Ordered return: INST then DATA accepted, responses come back in that order
    inst_req = 1; inst_addr = 32'h1c00_0008; mem_addr_ok = 1;
    #1;
    check("ord_inst_addr_ok", inst_addr_ok, 1);
    step();
    inst_req = 0; data_req = 1; data_addr = 32'h0000_0300;
    #1;
    check("ord_data_addr_ok", data_addr_ok, 1);
    step();
    data_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
    #1;
    check("ord_first_resp", {inst_data_ok, data_data_ok}, 2'b10);
    step();
    #1;
    check("ord_second_resp", {inst_data_ok, data_data_ok}, 2'b01);
    step();
    mem_data_ok = 0;

    // Stall lock: last winner is DATA, so INST would win a fresh tie; the lock must hold DATA
    data_req = 1; data_wr = 1; data_addr = 32'h0000_0100;
    data_wdata = 32'hdead_beef; data_wstrb = 4'hf; mem_addr_ok = 0;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin
        inst_req = 1; inst_addr = 32'h1c00_0010;
      end
      #1;
      check($sformatf("stall%0d_mem_req", c), mem_req, 1);
      check($sformatf("stall%0d_mem_addr", c), mem_addr, 32'h0000_0100);
      check($sformatf("stall%0d_mem_wr", c), mem_wr, 1);
      check($sformatf("stall%0d_addr_ok", c), {inst_addr_ok, data_addr_ok}, 0);
      step();
    end
    mem_addr_ok = 1;
    #1;
    check("stall_accept_data", {inst_addr_ok, data_addr_ok}, 2'b01);
    check("stall_accept_wdata", mem_wdata, 32'hdead_beef);
    check("stall_accept_wstrb", mem_wstrb, 4'hf);
    step();
    data_req = 0; data_wr = 0; data_wstrb = '0;
    #1;
    check("stall_then_inst", {inst_addr_ok, data_addr_ok}, 2'b10);
    check("stall_then_inst_addr", mem_addr, 32'h1c00_0010);
    check("stall_then_inst_wr", {mem_wr, mem_wstrb}, 0);
    step();

    // Full stall: two outstanding (DATA store, INST); third request must wait
    inst_addr = 32'h1c00_0014;
    #1;
    check("full_mem_req", mem_req, 0);
    check("full_addr_ok", {inst_addr_ok, data_addr_ok}, 0);
    step();
    mem_data_ok = 1;
    #1;
    check("full_pop_resp", {inst_data_ok, data_data_ok}, 2'b01);
    check("full_pop_same_cycle_mem_req", mem_req, 0);
    step();
    mem_data_ok = 0;
    #1;
    check("full_freed_mem_req", mem_req, 1);
    check("full_freed_inst_addr_ok", inst_addr_ok, 1);
    step();
    inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
    #1;
    check("full_drain1", {inst_data_ok, data_data_ok}, 2'b10);
    step();
    #1;
    check("full_drain2", {inst_data_ok, data_data_ok}, 2'b10);
    step();

    // Protocol error: response with nothing outstanding
    #1;
    check("perr_no_data_ok", {inst_data_ok, data_data_ok}, 0);
    check("perr_not_yet", proto_err, 0);
    step();
    mem_data_ok = 0;
    #1;
    check("perr_set", proto_err, 1);
    step();
    #1;
    check("perr_sticky", proto_err, 1);

    // Async reset mid-cycle: one outstanding, lock held with no live request
    inst_req = 1; inst_addr = 32'h1c00_0020; mem_addr_ok = 1;
    step();
    mem_addr_ok = 0;
    step();
    inst_req = 0;
    #1;
    check("pre_rst_locked_mem_req", mem_req, 1);
    #2;
    resetn = 1'b0;
    #1;
    check("async_rst_mem_req", mem_req, 0);
    check("async_rst_proto_err", proto_err, 0);
    #1;
    resetn = 1'b1;
    step();
    // Two back-to-back accepts only fit if the count was cleared
    inst_req = 1; inst_addr = 32'h1c00_0024; mem_addr_ok = 1;
    #1;
    check("post_rst_accept1", inst_addr_ok, 1);
    step();
    #1;
    check("post_rst_accept2", inst_addr_ok, 1);
    step();
    #1;
    check("post_rst_full", mem_req, 0);
    inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
    #1;
    check("post_rst_resp1", inst_data_ok, 1);
    step();
    #1;
    check("post_rst_resp2", inst_data_ok, 1);
    step();
    mem_data_ok = 0;
    #1;
    check("post_rst_no_perr", proto_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
